// File: rtl/game2048_pkg.sv
// Shared types for the 2048 front end: move directions and command-queue FSM states.
package game2048_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   // Lowest-index press wins when several buttons fire together.
   function automatic dir_t pick_dir(input logic [3:0] down);
      if (down[0])      return DIR_UP;
      else if (down[1]) return DIR_DOWN;
      else if (down[2]) return DIR_LEFT;
      else              return DIR_RIGHT;
   endfunction

endpackage

// File: rtl/move_command_queue_if.sv
// Valid/ready command stream from the move queue to the game engine.
interface move_command_queue_if;

   logic                valid;
   game2048_pkg::dir_t  dir;
   logic                ready;

   modport master (output valid, output dir, input ready);
   modport slave  (input valid, input dir, output ready);

endinterface

// File: rtl/move_fifo.sv
// First-word-fall-through FIFO of 2-bit move commands; head is always visible on rd_dir.
module move_fifo
   import game2048_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push,
   input  dir_t wr_dir,
   input  logic pop,
   output dir_t rd_dir,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   dir_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_pop;
   logic          do_push;

   // A pop on empty is ignored; a push on full only lands if a pop frees the slot.
   assign do_pop  = pop & (count != '0);
   assign do_push = push & ((count != FULL_CNT) | do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_dir;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign rd_dir = mem[rd_ptr];
   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);

endmodule

// File: rtl/move_command_queue.sv
// Turns debounced button presses/holds into queued move commands with auto-repeat.
//   state     | meaning
//   ST_IDLE   | no button tracked
//   ST_HOLD   | button pressed, waiting HOLD_CYCLES for first repeat
//   ST_REPEAT | button still held, one command every REPEAT_CYCLES
module move_command_queue
   import game2048_pkg::*;
#(
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 6_250_000,
   parameter int CNT_WIDTH     = 26,
   parameter int DEPTH         = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [3:0]                  btn_down_i,
   input  logic [3:0]                  btn_state_i,
   move_command_queue_if.master        move_if,
   output logic                        overflow_o
);

   localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

   state_t               state;
   dir_t                 cur_dir;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 push_q;
   dir_t                 push_dir_q;
   dir_t                 rd_dir;
   logic                 full;
   logic                 empty;
   logic                 pop;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         cur_dir    <= DIR_UP;
         cnt        <= '0;
         push_q     <= 1'b0;
         push_dir_q <= DIR_UP;
      end else begin
         push_q <= 1'b0;
         // A fresh press overrides any release/timeout in the same cycle.
         if (|btn_down_i) begin
            push_q     <= 1'b1;
            push_dir_q <= pick_dir(btn_down_i);
            cur_dir    <= pick_dir(btn_down_i);
            cnt        <= '0;
            state      <= ST_HOLD;
         end else begin
            unique case (state)
               ST_HOLD, ST_REPEAT: begin
                  if (!btn_state_i[cur_dir]) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end else if (cnt == ((state == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                     push_q     <= 1'b1;
                     push_dir_q <= cur_dir;
                     cnt        <= '0;
                     state      <= ST_REPEAT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign pop = move_if.valid & move_if.ready;

   move_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push   (push_q),
      .wr_dir (push_dir_q),
      .pop    (pop),
      .rd_dir (rd_dir),
      .full   (full),
      .empty  (empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) overflow_o <= 1'b0;
      else       overflow_o <= push_q & full & ~pop;
   end

   assign move_if.valid = ~empty;
   assign move_if.dir   = rd_dir;

endmodule

// File: tb/tb_move_command_queue.sv
// Randomised and directed stimulus against a timestamp/queue reference model of the move queue.
module tb_move_command_queue;

   localparam int H     = 10;
   localparam int R     = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_down;
   logic [3:0] btn_state;
   logic       overflow;

   move_command_queue_if mif ();

   move_command_queue #(
      .HOLD_CYCLES   (H),
      .REPEAT_CYCLES (R),
      .CNT_WIDTH     (8),
      .DEPTH         (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .btn_down_i  (btn_down),
      .btn_state_i (btn_state),
      .move_if     (mif),
      .overflow_o  (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: a queue of commands plus the time the next auto-repeat is due.
   int q[$];
   int pend;
   bit tracking;
   int track;
   int next_rep;
   int t;
   bit exp_ovf;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0d", tag, got, exp, t);
      end
   endtask

   task automatic step();
      bit pop;
      @(posedge clk);
      t++;
      if (rst) begin
         q.delete();
         pend     = -1;
         tracking = 0;
         exp_ovf  = 0;
      end else begin
         pop     = (q.size() > 0) && mif.ready;
         exp_ovf = 0;
         if (pop) void'(q.pop_front());
         if (pend >= 0) begin
            if (q.size() < DEPTH) q.push_back(pend);
            else                  exp_ovf = 1;
         end
         pend = -1;
         if (btn_down != 4'd0) begin
            int d = 0;
            while (!btn_down[d]) d++;
            pend     = d;
            tracking = 1;
            track    = d;
            next_rep = t + H;
         end else if (tracking && !btn_state[track]) begin
            tracking = 0;
         end else if (tracking && t == next_rep) begin
            pend     = track;
            next_rep = t + R;
         end
      end
      #1;
      chk("valid", int'(mif.valid), int'(q.size() > 0));
      chk("overflow", int'(overflow), int'(exp_ovf));
      if (q.size() > 0) chk("dir", int'(mif.dir), q[0]);
      else if (rst)     chk("dir_reset", int'(mif.dir), 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      pend = -1; tracking = 0; t = 0; exp_ovf = 0;
      rst = 1'b1; btn_down = 4'b1111; btn_state = 4'b1111; mif.ready = 1'b0;
      idle(2);
      rst = 1'b0; btn_down = 4'b0000; btn_state = 4'b0000;
      idle(4);

      // single press of left
      mif.ready = 1'b1; btn_down = 4'b0100; btn_state = 4'b0100;
      step();
      btn_down = 4'b0000;
      idle(2);
      btn_state = 4'b0000;
      idle(4);

      // simultaneous down+right press
      btn_down = 4'b1010; btn_state = 4'b1010;
      step();
      btn_down = 4'b0000; btn_state = 4'b0000;
      idle(4);

      // auto-repeat on right
      btn_down = 4'b1000; btn_state = 4'b1000;
      step();
      btn_down = 4'b0000;
      idle(29);
      btn_state = 4'b0000;
      idle(12);

      // overflow with backpressure
      mif.ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         btn_down = 4'b0001 << (i % 4);
         step();
         btn_down = 4'b0000;
         step();
      end
      idle(3);
      mif.ready = 1'b1;
      idle(7);

      // full FIFO with pop coinciding with the push of a left press
      mif.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         btn_down = 4'b0001 << i;
         step();
         btn_down = 4'b0000;
         step();
      end
      btn_down = 4'b0100;
      step();
      btn_down = 4'b0000; mif.ready = 1'b1;
      step();
      mif.ready = 1'b0;
      idle(2);
      mif.ready = 1'b1;
      idle(6);

      // random phase
      for (int i = 0; i < 2000; i++) begin
         if (i % 60 == 0) mif.ready = ($urandom_range(0, 2) != 0);
         if (i % 60 > 30) mif.ready = ($urandom_range(0, 1) != 0);
         btn_down = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         if ($urandom_range(0, 19) == 0) btn_state = 4'($urandom_range(0, 15));
         btn_state = btn_state | btn_down;
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0; btn_down = 4'd0; btn_state = 4'd0; mif.ready = 1'b1;
      idle(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
